// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter.
package mem_arb_pkg;
  localparam int ADDR_W_DEF       = 32;
  localparam int DATA_W_DEF       = 32;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int CNT_W            = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, ERR} arb_state_e;
  typedef enum logic {SRC_INSTR, SRC_DATA} arb_src_e;
endpackage

// File: rtl/arb_starve_select.sv
// Data-priority winner select with a starvation counter that forces a fetch win.
module arb_starve_select
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic arb_en,
  input  logic ireq_valid,
  input  logic dreq_valid,
  input  logic flush,
  output logic grant_instr,
  output logic grant_data
);
  logic [CNT_W-1:0] starve_cnt;
  logic             ivld;
  logic             starved;

  // A flushing fetch side is not a candidate, so it cannot claim the slot.
  assign ivld        = ireq_valid & ~flush;
  assign starved     = (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign grant_data  = arb_en & dreq_valid & ~(ivld & starved);
  assign grant_instr = arb_en & ivld & ~grant_data;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_cnt <= '0;
    end else if (grant_instr) begin
      starve_cnt <= '0;
    end else if (grant_data) begin
      if (!ireq_valid)  starve_cnt <= '0;
      else if (!starved) starve_cnt <= starve_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one req/gnt/rvalid memory port between fetch and data requesters,
// one outstanding transaction, response routed back to the originator.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                ireq_valid_i,
  output logic                ireq_ready_o,
  input  logic [ADDR_W-1:0]   ireq_addr_i,
  output logic                iresp_valid_o,
  output logic [DATA_W-1:0]   iresp_rdata_o,
  output logic                iresp_err_o,
  input  logic                flush_i,
  input  logic                dreq_valid_i,
  output logic                dreq_ready_o,
  input  logic                dreq_we_i,
  input  logic [ADDR_W-1:0]   dreq_addr_i,
  input  logic [DATA_W-1:0]   dreq_wdata_i,
  input  logic [DATA_W/8-1:0] dreq_wstrb_i,
  output logic                dresp_valid_o,
  output logic [DATA_W-1:0]   dresp_rdata_o,
  output logic                dresp_err_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wstrb_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);
  localparam int STRB_W = DATA_W / 8;

  typedef struct packed {
    arb_src_e          src;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } mem_req_t;

  arb_state_e state;
  mem_req_t   req_q, req_d;
  logic       drop_q;
  logic       grant_i, grant_d;
  logic       instr_flush;

  arb_starve_select #(.STARVE_LIMIT(STARVE_LIMIT)) u_sel (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .arb_en      (state == IDLE),
    .ireq_valid  (ireq_valid_i),
    .dreq_valid  (dreq_valid_i),
    .flush       (flush_i),
    .grant_instr (grant_i),
    .grant_data  (grant_d)
  );

  assign ireq_ready_o = grant_i;
  assign dreq_ready_o = grant_d;
  assign instr_flush  = flush_i & (req_q.src == SRC_INSTR);

  assign mem_we_o    = req_q.we;
  assign mem_addr_o  = req_q.addr;
  assign mem_wdata_o = req_q.wdata;
  assign mem_wstrb_o = req_q.wstrb;

  always_comb begin
    req_d = req_q;
    if (grant_d) begin
      req_d.src   = SRC_DATA;
      req_d.we    = dreq_we_i;
      req_d.addr  = dreq_addr_i;
      req_d.wdata = dreq_wdata_i;
      req_d.wstrb = dreq_wstrb_i;
    end else if (grant_i) begin
      req_d.src   = SRC_INSTR;
      req_d.we    = 1'b0;
      req_d.addr  = ireq_addr_i;
      req_d.wdata = '0;
      req_d.wstrb = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      req_q         <= '0;
      drop_q        <= 1'b0;
      mem_req_o     <= 1'b0;
      iresp_valid_o <= 1'b0;
      iresp_rdata_o <= '0;
      iresp_err_o   <= 1'b0;
      dresp_valid_o <= 1'b0;
      dresp_rdata_o <= '0;
      dresp_err_o   <= 1'b0;
    end else begin
      iresp_valid_o <= 1'b0;
      iresp_err_o   <= 1'b0;
      dresp_valid_o <= 1'b0;
      dresp_err_o   <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_i || grant_d) begin
            req_q <= req_d;
            if (req_d.addr[1:0] != 2'b00) begin
              state <= ERR;
            end else begin
              state     <= ISSUE;
              mem_req_o <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (instr_flush) drop_q <= 1'b1;
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            state     <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (mem_rvalid_i) begin
            state  <= IDLE;
            drop_q <= 1'b0;
            if (req_q.src == SRC_DATA) begin
              dresp_valid_o <= 1'b1;
              dresp_rdata_o <= req_q.we ? '0 : mem_rdata_i;
            end else if (!(drop_q || instr_flush)) begin
              iresp_valid_o <= 1'b1;
              iresp_rdata_o <= mem_rdata_i;
            end
          end else if (instr_flush) begin
            drop_q <= 1'b1;
          end
        end
        ERR: begin
          state  <= IDLE;
          drop_q <= 1'b0;
          if (req_q.src == SRC_DATA) begin
            dresp_valid_o <= 1'b1;
            dresp_err_o   <= 1'b1;
          end else if (!(drop_q || instr_flush)) begin
            iresp_valid_o <= 1'b1;
            iresp_err_o   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: fetch/data arbitration, starvation order, stalls, errors, flush, reset.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          ireq_valid_i, ireq_ready_o;
  logic [AW-1:0] ireq_addr_i;
  logic          iresp_valid_o, iresp_err_o;
  logic [DW-1:0] iresp_rdata_o;
  logic          flush_i;
  logic          dreq_valid_i, dreq_ready_o, dreq_we_i;
  logic [AW-1:0] dreq_addr_i;
  logic [DW-1:0] dreq_wdata_i;
  logic [SW-1:0] dreq_wstrb_i;
  logic          dresp_valid_o, dresp_err_o;
  logic [DW-1:0] dresp_rdata_o;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [SW-1:0] mem_wstrb_o;
  logic          mem_gnt_i, mem_rvalid_i;
  logic [DW-1:0] mem_rdata_i;

  int vec_cnt = 0, err_cnt = 0, cyc = 0;
  int i_cnt = 0, d_cnt = 0, i_cyc = 0, d_cyc = 0, both_hi = 0;
  logic [DW-1:0] i_dat = '0, d_dat = '0;
  logic i_err = 1'b0, d_err = 1'b0;

  int gnt_dly = 0, req_wait = 0, req_cycles = 0, unstable = 0, gnt_cnt = 0;
  logic rsp_pend = 1'b0;
  logic [DW-1:0] mem_data = '0;
  logic [AW-1:0] cap_addr = '0;
  logic [DW-1:0] cap_wdata = '0;
  logic [SW-1:0] cap_wstrb = '0;
  logic          cap_we = 1'b0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ireq_valid_i(ireq_valid_i), .ireq_ready_o(ireq_ready_o), .ireq_addr_i(ireq_addr_i),
    .iresp_valid_o(iresp_valid_o), .iresp_rdata_o(iresp_rdata_o), .iresp_err_o(iresp_err_o),
    .flush_i(flush_i),
    .dreq_valid_i(dreq_valid_i), .dreq_ready_o(dreq_ready_o), .dreq_we_i(dreq_we_i),
    .dreq_addr_i(dreq_addr_i), .dreq_wdata_i(dreq_wdata_i), .dreq_wstrb_i(dreq_wstrb_i),
    .dresp_valid_o(dresp_valid_o), .dresp_rdata_o(dresp_rdata_o), .dresp_err_o(dresp_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  initial forever #5 clk_i = ~clk_i;
  initial forever begin @(posedge clk_i); cyc++; end

  initial begin
    #200000;
    $display("FAIL timeout: sim time %0t exceeded limit", $time);
    $fatal(1, "timeout");
  end

  // Response monitor
  initial forever begin
    @(negedge clk_i);
    if (iresp_valid_o) begin i_cnt++; i_cyc = cyc; i_dat = iresp_rdata_o; i_err = iresp_err_o; end
    if (dresp_valid_o) begin d_cnt++; d_cyc = cyc; d_dat = dresp_rdata_o; d_err = dresp_err_o; end
    if (iresp_valid_o && dresp_valid_o) both_hi++;
  end

  // Memory model: gnt after gnt_dly request cycles, rvalid the cycle after gnt
  initial begin
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      mem_rvalid_i = rsp_pend;
      mem_rdata_i  = rsp_pend ? mem_data : '0;
      rsp_pend     = 1'b0;
      mem_gnt_i    = 1'b0;
      if (mem_req_o) begin
        req_cycles++;
        if (req_cycles == 1) begin
          cap_addr = mem_addr_o; cap_wdata = mem_wdata_o; cap_wstrb = mem_wstrb_o; cap_we = mem_we_o;
        end else if (cap_addr != mem_addr_o || cap_wdata != mem_wdata_o ||
                     cap_wstrb != mem_wstrb_o || cap_we != mem_we_o) begin
          unstable++;
        end
        if (req_wait >= gnt_dly) begin
          mem_gnt_i = 1'b1; rsp_pend = 1'b1; req_wait = 0; gnt_cnt++;
        end else begin
          req_wait++;
        end
      end else begin
        req_wait = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Presents one request, returns accept cycle; leaves caller at the negedge after accept
  task automatic do_req(input bit is_d, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [SW-1:0] strb, output int acc);
    bit got;
    got = 1'b0;
    acc = -1;
    @(negedge clk_i);
    if (is_d) begin
      dreq_valid_i = 1'b1; dreq_we_i = we; dreq_addr_i = addr;
      dreq_wdata_i = wdata; dreq_wstrb_i = strb;
    end else begin
      ireq_valid_i = 1'b1; ireq_addr_i = addr;
    end
    for (int n = 0; n < 20 && !got; n++) begin
      #1;
      if (is_d ? dreq_ready_o : ireq_ready_o) begin got = 1'b1; acc = cyc; end
      else @(negedge clk_i);
    end
    chk("accept", 64'(got), 64'd1);
    @(negedge clk_i);
    ireq_valid_i = 1'b0; dreq_valid_i = 1'b0;
  endtask

  initial begin
    int acc, i0, d0, g0, g;
    logic [9:0] exp_i;
    rst_i = 1'b1; flush_i = 1'b0;
    ireq_valid_i = 1'b0; ireq_addr_i = '0;
    dreq_valid_i = 1'b0; dreq_we_i = 1'b0; dreq_addr_i = '0; dreq_wdata_i = '0; dreq_wstrb_i = '0;
    wait_cyc(2);
    #1;
    chk("rst_mem_req", 64'(mem_req_o), 64'd0);
    chk("rst_iresp_v", 64'(iresp_valid_o), 64'd0);
    chk("rst_dresp_v", 64'(dresp_valid_o), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Fetch only, zero-wait
    gnt_dly = 0; mem_data = 32'h0000_0013; d0 = d_cnt; i0 = i_cnt;
    do_req(1'b0, 1'b0, 32'h8000_0000, '0, '0, acc);
    chk("f_mem_req", 64'(mem_req_o), 64'd1);
    chk("f_mem_addr", 64'(mem_addr_o), 64'h8000_0000);
    chk("f_mem_we", 64'(mem_we_o), 64'd0);
    wait_cyc(5);
    chk("f_icnt", 64'(i_cnt - i0), 64'd1);
    chk("f_icyc", 64'(i_cyc - acc), 64'd3);
    chk("f_idat", 64'(i_dat), 64'h13);
    chk("f_ierr", 64'(i_err), 64'd0);
    chk("f_nodresp", 64'(d_cnt - d0), 64'd0);

    // Both valid continuously: D,D,D,D,I,D,D,D,D,I
    exp_i = 10'b10_0001_0000; mem_data = 32'h1234_5678; g = 0;
    @(negedge clk_i);
    ireq_valid_i = 1'b1; ireq_addr_i = 32'h8000_0100;
    dreq_valid_i = 1'b1; dreq_we_i = 1'b0; dreq_addr_i = 32'h8000_2000;
    for (int n = 0; n < 100 && g < 10; n++) begin
      #1;
      if (ireq_ready_o || dreq_ready_o) begin
        chk("starve_grant", 64'({ireq_ready_o, dreq_ready_o}), exp_i[g] ? 64'd2 : 64'd1);
        g++;
      end
      if (g < 10) @(negedge clk_i);
    end
    chk("starve_ngrant", 64'(g), 64'd10);
    @(negedge clk_i);
    ireq_valid_i = 1'b0; dreq_valid_i = 1'b0;
    wait_cyc(5);
    chk("starve_ddat", 64'(d_dat), 64'h1234_5678);

    // Store with gnt delayed 3 cycles
    gnt_dly = 3; mem_data = 32'h55AA_55AA; req_cycles = 0; unstable = 0; d0 = d_cnt;
    do_req(1'b1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF, acc);
    wait_cyc(8);
    chk("st_req_cycles", 64'(req_cycles), 64'd4);
    chk("st_unstable", 64'(unstable), 64'd0);
    chk("st_addr", 64'(cap_addr), 64'h8000_1000);
    chk("st_wdata", 64'(cap_wdata), 64'hDEAD_BEEF);
    chk("st_wstrb_we", 64'({cap_wstrb, cap_we}), 64'h1F);
    chk("st_dcnt", 64'(d_cnt - d0), 64'd1);
    chk("st_dcyc", 64'(d_cyc - acc), 64'd6);
    chk("st_rdata0", 64'(d_dat), 64'd0);

    // Misaligned load
    gnt_dly = 0; req_cycles = 0; d0 = d_cnt;
    do_req(1'b1, 1'b0, 32'h8000_1002, '0, 4'hF, acc);
    wait_cyc(5);
    chk("mis_noreq", 64'(req_cycles), 64'd0);
    chk("mis_dcnt", 64'(d_cnt - d0), 64'd1);
    chk("mis_dcyc", 64'(d_cyc - acc), 64'd2);
    chk("mis_err", 64'(d_err), 64'd1);

    // Flush in WAIT_RSP
    mem_data = 32'h0000_AAAA; i0 = i_cnt; g0 = gnt_cnt;
    do_req(1'b0, 1'b0, 32'h8000_0004, '0, '0, acc);
    @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    wait_cyc(4);
    chk("flw_drop", 64'(i_cnt - i0), 64'd0);
    chk("flw_bus", 64'(gnt_cnt - g0), 64'd1);

    // Flush in ISSUE while gnt stalls
    gnt_dly = 2; i0 = i_cnt; g0 = gnt_cnt;
    do_req(1'b0, 1'b0, 32'h8000_0008, '0, '0, acc);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    wait_cyc(6);
    chk("fli_drop", 64'(i_cnt - i0), 64'd0);
    chk("fli_bus", 64'(gnt_cnt - g0), 64'd1);

    // Next fetch responds normally
    gnt_dly = 0; mem_data = 32'h0010_0093; i0 = i_cnt;
    do_req(1'b0, 1'b0, 32'h8000_0040, '0, '0, acc);
    wait_cyc(5);
    chk("fpost_icnt", 64'(i_cnt - i0), 64'd1);
    chk("fpost_icyc", 64'(i_cyc - acc), 64'd3);
    chk("fpost_idat", 64'(i_dat), 64'h0010_0093);

    // Reset during ISSUE
    gnt_dly = 5; i0 = i_cnt; d0 = d_cnt;
    do_req(1'b0, 1'b0, 32'h8000_0080, '0, '0, acc);
    chk("rst_pre_req", 64'(mem_req_o), 64'd1);
    #2 rst_i = 1'b1;
    #1 chk("rst_async_req", 64'(mem_req_o), 64'd0);
    chk("rst_irdata", 64'(iresp_rdata_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    wait_cyc(8);
    chk("rst_noresp", 64'(i_cnt - i0), 64'd0);
    chk("rst_idle_req", 64'(mem_req_o), 64'd0);
    gnt_dly = 0; mem_data = 32'h0BAD_F00D;
    do_req(1'b1, 1'b0, 32'h8000_3000, '0, 4'hF, acc);
    wait_cyc(5);
    chk("rpost_dcnt", 64'(d_cnt - d0), 64'd1);
    chk("rpost_dcyc", 64'(d_cyc - acc), 64'd3);
    chk("rpost_ddat", 64'(d_dat), 64'h0BAD_F00D);

    chk("never_both", 64'(both_hi), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single core memory port between the fetch stage (instruction reads) and the memory stage (data loads/stores). Accepts one request at a time over valid/ready, drives a req/gnt/rvalid memory bus with exactly one outstanding transaction, and routes the response back to the originating requester. Data has priority, with a starvation limit guaranteeing fetch progress. Fetch-side flush discards stale instruction responses after a redirect.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive data wins tolerated while fetch is waiting; range 1..15
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset; **one clock; reset is asynchronous and active-high**
- ireq_valid_i / ireq_ready_o  in/out  1  fetch request handshake
- ireq_addr_i  in  ADDR_W  fetch address
- iresp_valid_o  out  1  one-cycle fetch response pulse
- iresp_rdata_o  out  DATA_W  instruction word
- iresp_err_o  out  1  misaligned fetch
- flush_i  in  1  fetch redirect; drop any in-flight fetch
- dreq_valid_i / dreq_ready_o  in/out  1  data request handshake
- dreq_we_i  in  1  1 = store
- dreq_addr_i  in  ADDR_W  data address
- dreq_wdata_i  in  DATA_W  store data
- dreq_wstrb_i  in  DATA_W/8  byte strobes
- dresp_valid_o  out  1  one-cycle data response pulse
- dresp_rdata_o  out  DATA_W  load data; 0 for stores
- dresp_err_o  out  1  misaligned data access
- mem_req_o  out  1  memory request
- mem_we_o  out  1  write enable
- mem_addr_o  out  ADDR_W  address
- mem_wdata_o  out  DATA_W  write data
- mem_wstrb_o  out  DATA_W/8  strobes
- mem_gnt_i  in  1  request accepted by memory
- mem_rvalid_i  in  1  response valid
- mem_rdata_i  in  DATA_W  response data

## Operation
- FSM states: IDLE, ISSUE, WAIT_RSP, ERR.
- IDLE: arbitrate. ready_o is combinational and asserted only for the winner; handshake = valid & ready. On accept, latch source, we, addr, wdata, and wstrb.
  - Aligned: go to ISSUE.
  - addr[1:0] != 0: go to ERR.
- Arbitration: data wins if both are valid, unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
  - starve_cnt increments when data wins while ireq_valid_i = 1.
  - starve_cnt clears when fetch wins, or when data wins with ireq_valid_i = 0.
- ISSUE: mem_req_o = 1 with latched fields. Fields are held stable until mem_gnt_i; then go to WAIT_RSP.
- WAIT_RSP: on mem_rvalid_i, register rdata into the source's response outputs and pulse resp_valid next cycle; go to IDLE.
  - dresp_rdata_o = 0 for stores.
- ERR: no memory access; pulse the source's resp_valid with err = 1 next cycle; go to IDLE.
- Flush:
  - While flush_i = 1, ireq_ready_o = 0.
  - If flush_i is seen in ISSUE or WAIT_RSP with the latched source = fetch, set a drop flag. The transaction completes on the bus, but iresp_valid_o is suppressed.
  - A flush pending from ERR also suppresses the error pulse.
  - The drop flag clears on return to IDLE.
  - Data transactions are never affected by flush.
- Response outputs hold their last value between pulses; only valid/err pulse.

## Timing
- Reset: all outputs 0, state IDLE, starve_cnt 0, drop flag 0. Reset mid-transaction deasserts mem_req_o immediately (async) and no response is generated.
- Zero-wait memory (gnt in ISSUE cycle, rvalid in first WAIT_RSP cycle): accept at cycle N, mem_req_o at N+1, resp_valid at N+3.
- Misaligned: accept at N, err pulse at N+2.
- Back-to-back: a new accept may occur in the cycle resp_valid is high. Sustained throughput is 1 transaction per 3 cycles.
- At most one response pulse per accepted request (zero if dropped). iresp_valid_o and dresp_valid_o are never high together.
- mem_rvalid_i outside WAIT_RSP is ignored. mem_gnt_i outside ISSUE is ignored.

## Structure
- Shared package mem_arb_pkg:
  - state enum (IDLE/ISSUE/WAIT_RSP/ERR)
  - source enum (SRC_INSTR/SRC_DATA)
  - default ADDR_W/DATA_W
  - STARVE_LIMIT default
- Sub-module arb_starve_select: winner selection plus the starve_cnt register. Inputs: both valids, flush, an "arbitrating" enable. Outputs: grant_instr, grant_data.

## Test plan
- Fetch only, zero-wait memory: ireq addr 0x8000_0000, mem_rdata 0x0000_0013 -> ireq_ready_o high at N, mem_req_o at N+1, iresp_valid_o with 0x0000_0013 at N+3, no dresp.
- Simultaneous ireq and dreq held valid continuously, STARVE_LIMIT = 4 -> grant order D,D,D,D,I,D,D,D,D,I.
- Store addr 0x8000_1000, wdata 0xDEADBEEF, wstrb 0xF, gnt delayed 3 cycles -> mem fields stable for all 4 request cycles; dresp_valid_o with rdata 0 after rvalid.
- Load addr 0x8000_1002 -> no mem_req_o; dresp_valid_o with dresp_err_o = 1 at N+2.
- Fetch accepted, flush_i pulsed in WAIT_RSP -> bus transaction completes, no iresp_valid_o; next fetch responds normally.
- rst_i asserted during ISSUE -> mem_req_o 0 in the same cycle, no response after release, next request handled from IDLE.
